dcfifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one dual-clock FIFO write port among NREQ producers in the wr_clk domain (for example, several FIR channel outputs feeding one CDC FIFO).
- Grants one requester at a time for a burst of up to BURST words.
- Gates every write on the FIFO full flag, so the FIFO never overflows.
- Sits directly in front of the FIFO write port. It produces the FIFO's datain and write inputs and consumes its full output.

---
 rtl/dcfifo_wr_arbiter_pkg.sv | 41 ++++
 rtl/dcfifo_wr_arbiter_rr_pick.sv | 25 ++
 rtl/dcfifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_dcfifo_wr_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcfifo_wr_arbiter_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// The search is written for up to 8 requesters; callers zero-pad narrower vectors.
package dcfifo_wr_arbiter_pkg;

    localparam int RR_MAX = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_result_t;

    // Visit last+1, last+2, ... wrapping at nreq; the first valid index wins,
    // so the previous winner is always examined last.
    function automatic rr_result_t rr_next(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        last,
        input int unsigned       nreq
    );
        rr_result_t  res;
        int unsigned j;
        res.found = 1'b0;
        res.idx   = last;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            j = 32'(last) + i;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if ((i <= nreq) && !res.found && valid[j[2:0]]) begin
                res.found = 1'b1;
                res.idx   = j[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcfifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the next valid requester after last_idx.
module dcfifo_wr_arbiter_rr_pick
    import dcfifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   last_idx,
    output logic [IW-1:0]   win_idx,
    output logic            found
);

    logic [RR_MAX-1:0] valid_pad;
    rr_result_t        res;

    always_comb begin
        valid_pad             = '0;
        valid_pad[NREQ-1:0]   = req_valid;
        res                   = rr_next(valid_pad, 3'(last_idx), NREQ);
        found                 = res.found;
        win_idx               = IW'(res.idx);
    end

endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// Round-robin arbiter sharing one dual-clock FIFO write port among NREQ producers,
// granting bursts of up to BURST words and never writing while the FIFO is full.
module dcfifo_wr_arbiter
    import dcfifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int DWIDTH = 16,
    parameter  int BURST  = 4,
    parameter  int SWIDTH = 16,
    localparam int IW     = $clog2(NREQ),
    localparam int CW     = $clog2(BURST + 1)
) (
    input  logic                   wr_clk,
    input  logic                   areset_n_wr,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_full,
    output logic [DWIDTH-1:0]      fifo_datain,
    output logic                   fifo_write,
    output logic [IW-1:0]          grant_id,
    output logic                   busy,
    output logic [SWIDTH-1:0]      stall_cnt
);

    localparam logic [CW-1:0]     LAST_CNT  = CW'(BURST - 1);
    localparam logic [IW-1:0]     RESET_GNT = IW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [CW-1:0]   burst_cnt, cnt_nxt;
    logic [IW-1:0]   win_idx;
    logic            found;
    logic            valid_g;
    logic            xfer;
    logic            stall;

    dcfifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .last_idx  (grant_id),
        .win_idx   (win_idx),
        .found     (found)
    );

    always_ff @(posedge wr_clk or negedge areset_n_wr) begin
        if (!areset_n_wr) begin
            state     <= ST_IDLE;
            grant_id  <= RESET_GNT;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Handshake: a word moves on a rising edge where req_valid[k] && req_ready[k];
    // req_ready only depends on grant and fifo_full, never on req_valid, and the
    // same condition drives fifo_write, so the FIFO and the producer always agree.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        cnt_nxt     = burst_cnt;
        req_ready   = '0;
        fifo_write  = 1'b0;
        fifo_datain = '0;
        busy        = 1'b0;
        valid_g     = req_valid[grant_id];
        xfer        = 1'b0;
        stall       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_nxt = win_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANT;
                end
            end

            ST_GRANT: begin
                busy                = 1'b1;
                req_ready[grant_id] = !fifo_full;
                fifo_datain         = req_data[grant_id*DWIDTH +: DWIDTH];
                xfer                = valid_g && !fifo_full;
                stall               = valid_g && fifo_full;
                fifo_write          = xfer;

                if (!valid_g) begin
                    state_nxt = ST_IDLE;
                end else if (xfer) begin
                    cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == LAST_CNT) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating count of granted cycles blocked only by a full FIFO.
    always_ff @(posedge wr_clk or negedge areset_n_wr) begin
        if (!areset_n_wr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// Bench for dcfifo_wr_arbiter: per-cycle vector tables plus a write scoreboard
// holding {grant_id, data} of every word expected at the FIFO port, in order.
module tb_dcfifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int BURST = 4;
    localparam int SW    = 16;
    localparam int IW    = 2;
    localparam int QW    = IW + DW;

    logic                 wr_clk      = 1'b0;
    logic                 areset_n_wr = 1'b0;
    logic [NREQ-1:0]      req_valid   = '0;
    logic [NREQ*DW-1:0]   req_data    = '0;
    logic                 fifo_full   = 1'b0;

    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        fifo_datain;
    logic                 fifo_write;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic [SW-1:0]        stall_cnt;

    logic [NREQ-1:0]      sat_ready;
    logic [DW-1:0]        sat_datain;
    logic                 sat_write;
    logic [IW-1:0]        sat_grant;
    logic                 sat_busy;
    logic [3:0]           sat_stall;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            full;
        logic            write;
        logic [NREQ-1:0] ready;
        logic            busy;
        logic [IW-1:0]   grant;
    } vec_t;

    vec_t          tbl[$];
    logic [QW-1:0] exp_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            wr_cnt = 0;
    int            seq[NREQ];

    dcfifo_wr_arbiter #(
        .NREQ(NREQ), .DWIDTH(DW), .BURST(BURST), .SWIDTH(SW)
    ) dut (
        .wr_clk(wr_clk), .areset_n_wr(areset_n_wr),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_datain(fifo_datain), .fifo_write(fifo_write),
        .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
    );

    dcfifo_wr_arbiter #(
        .NREQ(NREQ), .DWIDTH(DW), .BURST(BURST), .SWIDTH(4)
    ) dut_sat (
        .wr_clk(wr_clk), .areset_n_wr(areset_n_wr),
        .req_valid(req_valid), .req_data(req_data), .req_ready(sat_ready),
        .fifo_full(fifo_full), .fifo_datain(sat_datain), .fifo_write(sat_write),
        .grant_id(sat_grant), .busy(sat_busy), .stall_cnt(sat_stall)
    );

    // clock / watchdog
    always #5 wr_clk = ~wr_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] word(input int k, input int s);
        return DW'(32'h0A00 + (k << 12) + s);
    endfunction

    task automatic drive_data();
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = word(k, seq[k]);
    endtask

    task automatic push(input int k, input int s);
        exp_q.push_back({IW'(k), word(k, s)});
    endtask

    // Called between negedge and posedge: producers advance after an accepted word.
    task automatic tick();
        logic [NREQ-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge wr_clk);
        #1;
        for (int k = 0; k < NREQ; k++) if (acc[k]) seq[k]++;
        drive_data();
    endtask

    task automatic step();
        @(negedge wr_clk);
        tick();
    endtask

    task automatic add(input logic [NREQ-1:0] v, input logic f, input logic w,
                       input logic [NREQ-1:0] r, input logic b, input logic [IW-1:0] g);
        vec_t e;
        e.valid = v; e.full = f; e.write = w; e.ready = r; e.busy = b; e.grant = g;
        tbl.push_back(e);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            req_valid = tbl[i].valid;
            fifo_full = tbl[i].full;
            @(negedge wr_clk);
            chk($sformatf("%s[%0d].write", name, i), fifo_write, tbl[i].write);
            chk($sformatf("%s[%0d].ready", name, i), req_ready,  tbl[i].ready);
            chk($sformatf("%s[%0d].busy",  name, i), busy,       tbl[i].busy);
            chk($sformatf("%s[%0d].grant", name, i), grant_id,   tbl[i].grant);
            tick();
        end
        tbl.delete();
        chk({name, ".drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        areset_n_wr = 1'b0;
        req_valid   = '0;
        fifo_full   = 1'b0;
        for (int k = 0; k < NREQ; k++) seq[k] = 0;
        drive_data();
        exp_q.delete();
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("rst.ready",  req_ready,   0);
        chk("rst.write",  fifo_write,  0);
        chk("rst.busy",   busy,        0);
        chk("rst.datain", fifo_datain, 0);
        chk("rst.stall",  stall_cnt,   0);
        chk("rst.grant",  grant_id,    3);
        #1 areset_n_wr = 1'b1;
        @(posedge wr_clk);
        #1;
    endtask

    // scoreboard
    always @(negedge wr_clk) begin
        if (areset_n_wr && fifo_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got grant %0d data 0x%0h, expected no write",
                         grant_id, fifo_datain);
            end else begin
                chk("write_data", {grant_id, fifo_datain}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int w0;
        for (int k = 0; k < NREQ; k++) seq[k] = 0;

        // single requester: bubble, 4-word burst, bubble, 2 more words
        do_reset();
        for (int s = 0; s < 6; s++) push(0, s);
        add(4'b0001, 0, 0, 4'b0000, 0, 3);
        for (int c = 0; c < 4; c++) add(4'b0001, 0, 1, 4'b0001, 1, 0);
        add(4'b0001, 0, 0, 4'b0000, 0, 0);
        for (int c = 0; c < 2; c++) add(4'b0001, 0, 1, 4'b0001, 1, 0);
        add(4'b0000, 0, 0, 4'b0001, 1, 0);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("single");

        // all requesters valid: grants 0,1,2,3,0, 20 writes in 25 cycles
        do_reset();
        for (int g = 0; g < 4; g++) for (int s = 0; s < 4; s++) push(g, s);
        for (int s = 4; s < 8; s++) push(0, s);
        req_valid = 4'b1111;
        w0 = wr_cnt;
        repeat (25) step();
        chk("rr.writes", wr_cnt - w0, 20);
        req_valid = '0;
        repeat (2) step();
        chk("rr.drained", exp_q.size(), 0);

        // requester 2 stalled by fifo_full for 7 cycles mid-burst
        do_reset();
        for (int s = 0; s < 4; s++) push(2, s);
        add(4'b0100, 0, 0, 4'b0000, 0, 3);
        for (int c = 0; c < 2; c++) add(4'b0100, 0, 1, 4'b0100, 1, 2);
        for (int c = 0; c < 7; c++) add(4'b0100, 1, 0, 4'b0000, 1, 2);
        for (int c = 0; c < 2; c++) add(4'b0100, 0, 1, 4'b0100, 1, 2);
        add(4'b0000, 0, 0, 4'b0000, 0, 2);
        run_table("stall");
        chk("stall.cnt", stall_cnt, 7);
        chk("stall.cnt_sat_inst", sat_stall, 7);

        // requester 1 drops valid after 2 words; requester 3 wins next
        do_reset();
        push(1, 0); push(1, 1);
        for (int s = 0; s < 4; s++) push(3, s);
        add(4'b0010, 0, 0, 4'b0000, 0, 3);
        for (int c = 0; c < 2; c++) add(4'b0010, 0, 1, 4'b0010, 1, 1);
        add(4'b1000, 0, 0, 4'b0010, 1, 1);
        add(4'b1000, 0, 0, 4'b0000, 0, 1);
        for (int c = 0; c < 4; c++) add(4'b1000, 0, 1, 4'b1000, 1, 3);
        add(4'b0000, 0, 0, 4'b0000, 0, 3);
        run_table("drop");

        // asynchronous reset mid-burst
        do_reset();
        push(2, 0);
        req_valid = 4'b0100;
        step();
        step();
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        #2 areset_n_wr = 1'b0;
        #1;
        chk("arst.write",  fifo_write,  0);
        chk("arst.ready",  req_ready,   0);
        chk("arst.busy",   busy,        0);
        chk("arst.datain", fifo_datain, 0);
        chk("arst.stall",  stall_cnt,   0);
        chk("arst.grant",  grant_id,    3);
        req_valid = '0;
        for (int k = 0; k < NREQ; k++) seq[k] = 0;
        drive_data();
        @(posedge wr_clk);
        @(negedge wr_clk);
        #1 areset_n_wr = 1'b1;
        @(posedge wr_clk);
        #1;
        push(0, 0);
        add(4'b1111, 0, 0, 4'b0000, 0, 3);
        add(4'b1111, 0, 1, 4'b0001, 1, 0);
        add(4'b0000, 0, 0, 4'b0001, 1, 0);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("after_arst");
        chk("after_arst.stall", stall_cnt, 0);

        // stall counter saturation (4-bit instance) vs unsaturated 16-bit count
        do_reset();
        req_valid = 4'b0001;
        step();
        fifo_full = 1'b1;
        repeat (20) step();
        chk("sat.cnt16", stall_cnt, 20);
        chk("sat.cnt4",  sat_stall, 4'hF);
        chk("sat.busy",  busy,      1);
        repeat (3) step();
        chk("sat.cnt16_more", stall_cnt, 23);
        chk("sat.cnt4_hold",  sat_stall, 4'hF);
        fifo_full = 1'b0;
        req_valid = '0;
        repeat (2) step();
        chk("sat.drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
